// File: rtl/papu_pulse_noise.sv
// papu_pulse_noise
//   NES-APU style tone pair: one pulse (square) channel and one noise channel.
//   Both share the quarter/half-frame strobes and each drives a registered
//   4-bit DAC level towards the non-linear mixer.
//   Optional feature macro: PAPU_LENGTH_EN (per-channel length counters).
//   Without it the length mute is tied off and *_len_idx / hframe are ignored.
module papu_pulse_noise #(
    parameter logic [14:0] LFSR_SEED = 15'h0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        apu_ce,
    input  logic        qframe,
    input  logic        hframe,
    input  logic [7:0]  sq_reg0,
    input  logic [10:0] sq_period,
    input  logic        sq_restart,
    input  logic [4:0]  sq_len_idx,
    input  logic [7:0]  nz_reg0,
    input  logic [7:0]  nz_reg2,
    input  logic        nz_restart,
    input  logic [4:0]  nz_len_idx,
    output logic [3:0]  sq_out,
    output logic [3:0]  nz_out
);

    // Channel index 0 is the pulse channel, 1 is the noise channel.
    localparam int NCH = 2;

    // Noise timer reload values, indexed by nz_reg2[3:0].
    function automatic logic [11:0] nz_period_lut(input logic [3:0] idx);
        logic [11:0] val;
        case (idx)
            4'd0:    val = 12'd4;
            4'd1:    val = 12'd8;
            4'd2:    val = 12'd16;
            4'd3:    val = 12'd32;
            4'd4:    val = 12'd64;
            4'd5:    val = 12'd96;
            4'd6:    val = 12'd128;
            4'd7:    val = 12'd160;
            4'd8:    val = 12'd202;
            4'd9:    val = 12'd254;
            4'd10:   val = 12'd380;
            4'd11:   val = 12'd508;
            4'd12:   val = 12'd762;
            4'd13:   val = 12'd1016;
            4'd14:   val = 12'd2034;
            default: val = 12'd4068;
        endcase
        return val;
    endfunction

`ifdef PAPU_LENGTH_EN
    // Length counter load values, indexed by the 5-bit length index.
    function automatic logic [7:0] len_lut(input logic [4:0] idx);
        logic [7:0] val;
        case (idx)
            5'd0:    val = 8'd10;
            5'd1:    val = 8'd254;
            5'd2:    val = 8'd20;
            5'd3:    val = 8'd2;
            5'd4:    val = 8'd40;
            5'd5:    val = 8'd4;
            5'd6:    val = 8'd80;
            5'd7:    val = 8'd6;
            5'd8:    val = 8'd160;
            5'd9:    val = 8'd8;
            5'd10:   val = 8'd60;
            5'd11:   val = 8'd10;
            5'd12:   val = 8'd14;
            5'd13:   val = 8'd12;
            5'd14:   val = 8'd26;
            5'd15:   val = 8'd14;
            5'd16:   val = 8'd12;
            5'd17:   val = 8'd16;
            5'd18:   val = 8'd24;
            5'd19:   val = 8'd18;
            5'd20:   val = 8'd48;
            5'd21:   val = 8'd20;
            5'd22:   val = 8'd96;
            5'd23:   val = 8'd22;
            5'd24:   val = 8'd192;
            5'd25:   val = 8'd24;
            5'd26:   val = 8'd72;
            5'd27:   val = 8'd26;
            5'd28:   val = 8'd16;
            5'd29:   val = 8'd28;
            5'd30:   val = 8'd32;
            default: val = 8'd30;
        endcase
        return val;
    endfunction
`endif

    // Pulse channel state
    logic [10:0] sq_timer_q, sq_timer_d;
    logic [2:0]  sq_step_q, sq_step_d;
    logic [7:0]  sq_duty_pattern;
    logic        sq_duty_bit;

    // Noise channel state
    logic [11:0] nz_timer_q, nz_timer_d;
    logic [11:0] nz_period;
    logic [14:0] lfsr_q, lfsr_d;
    logic        lfsr_fb;

    // Per-channel views shared by the envelope / length generate loop
    logic [NCH-1:0] ch_restart;
    logic [5:0]     ch_ctrl   [NCH];
    logic [3:0]     ch_volume [NCH];
    logic [NCH-1:0] len_mute;

    // Registered DAC levels
    logic [3:0] sq_out_q, nz_out_q;

    // Register bits the channels never look at
    logic unused_inputs;

`ifdef PAPU_LENGTH_EN
    logic [4:0] ch_len_idx [NCH];
    assign ch_len_idx[0] = sq_len_idx;
    assign ch_len_idx[1] = nz_len_idx;
    assign unused_inputs = ^{nz_reg0[7:6], nz_reg2[6:4]};
`else
    assign unused_inputs = ^{hframe, sq_len_idx, nz_len_idx, nz_reg0[7:6], nz_reg2[6:4]};
`endif

    assign ch_restart = {nz_restart, sq_restart};
    assign ch_ctrl[0] = sq_reg0[5:0];
    assign ch_ctrl[1] = nz_reg0[5:0];

    // Pulse timer / duty sequencer next state; a restart overrides a timer tick.
    always_comb begin
        sq_timer_d = sq_timer_q;
        sq_step_d  = sq_step_q;
        if (sq_restart) begin
            sq_timer_d = sq_period;
            sq_step_d  = 3'd0;
        end else if (apu_ce) begin
            if (sq_timer_q == 11'd0) begin
                sq_timer_d = sq_period;
                sq_step_d  = sq_step_q + 3'd1;
            end else begin
                sq_timer_d = sq_timer_q - 11'd1;
            end
        end
    end

    // Pulse timer / duty sequencer registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sq_timer_q <= 11'd0;
            sq_step_q  <= 3'd0;
        end else begin
            sq_timer_q <= sq_timer_d;
            sq_step_q  <= sq_step_d;
        end
    end

    // Duty pattern selection; the waveform is read MSB first as the step advances.
    always_comb begin
        case (sq_reg0[7:6])
            2'd0:    sq_duty_pattern = 8'b0100_0000;
            2'd1:    sq_duty_pattern = 8'b0110_0000;
            2'd2:    sq_duty_pattern = 8'b0111_1000;
            default: sq_duty_pattern = 8'b1001_1111;
        endcase
    end
    assign sq_duty_bit = sq_duty_pattern[3'd7 - sq_step_q];

    // Noise feedback tap: mode bit is sampled live, so a mode change lands on the next shift.
    assign nz_period = nz_period_lut(nz_reg2[3:0]);
    assign lfsr_fb   = lfsr_q[0] ^ (nz_reg2[7] ? lfsr_q[6] : lfsr_q[1]);

    // Noise timer / LFSR next state; the LFSR shifts once per timer expiry.
    always_comb begin
        nz_timer_d = nz_timer_q;
        lfsr_d     = lfsr_q;
        if (apu_ce) begin
            if (nz_timer_q == 12'd0) begin
                nz_timer_d = nz_period;
                lfsr_d     = {lfsr_fb, lfsr_q[14:1]};
            end else begin
                nz_timer_d = nz_timer_q - 12'd1;
            end
        end
    end

    // Noise timer / LFSR registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nz_timer_q <= 12'd0;
            lfsr_q     <= LFSR_SEED;
        end else begin
            nz_timer_q <= nz_timer_d;
            lfsr_q     <= lfsr_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic       env_start_q, env_start_d;
            logic [3:0] env_decay_q, env_decay_d;
            logic [3:0] env_div_q,   env_div_d;

            // Envelope next state; a restart in the same cycle as qframe only arms start.
            always_comb begin
                env_start_d = env_start_q;
                env_decay_d = env_decay_q;
                env_div_d   = env_div_q;
                if (ch_restart[gi]) begin
                    env_start_d = 1'b1;
                end else if (qframe) begin
                    if (env_start_q) begin
                        env_start_d = 1'b0;
                        env_decay_d = 4'd15;
                        env_div_d   = ch_ctrl[gi][3:0];
                    end else if (env_div_q == 4'd0) begin
                        env_div_d = ch_ctrl[gi][3:0];
                        if (env_decay_q != 4'd0) begin
                            env_decay_d = env_decay_q - 4'd1;
                        end else if (ch_ctrl[gi][5]) begin
                            env_decay_d = 4'd15;
                        end
                    end else begin
                        env_div_d = env_div_q - 4'd1;
                    end
                end
            end

            // Envelope registers
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    env_start_q <= 1'b0;
                    env_decay_q <= 4'd0;
                    env_div_q   <= 4'd0;
                end else begin
                    env_start_q <= env_start_d;
                    env_decay_q <= env_decay_d;
                    env_div_q   <= env_div_d;
                end
            end

            assign ch_volume[gi] = ch_ctrl[gi][4] ? ch_ctrl[gi][3:0] : env_decay_q;

`ifdef PAPU_LENGTH_EN
            logic [7:0] len_q, len_d;

            // Length counter next state; a load on restart suppresses that cycle's decrement.
            always_comb begin
                len_d = len_q;
                if (ch_restart[gi]) begin
                    len_d = len_lut(ch_len_idx[gi]);
                end else if (hframe && !ch_ctrl[gi][5] && (len_q != 8'd0)) begin
                    len_d = len_q - 8'd1;
                end
            end

            // Length counter register
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    len_q <= 8'd0;
                end else begin
                    len_q <= len_d;
                end
            end

            assign len_mute[gi] = (len_q == 8'd0);
`else
            assign len_mute[gi] = 1'b0;
`endif
        end
    endgenerate

    // Output levels, registered one cycle behind the internal channel state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sq_out_q <= 4'd0;
            nz_out_q <= 4'd0;
        end else begin
            sq_out_q <= (sq_duty_bit && (sq_period >= 11'd8) && !len_mute[0]) ? ch_volume[0] : 4'd0;
            nz_out_q <= (!lfsr_q[0] && !len_mute[1]) ? ch_volume[1] : 4'd0;
        end
    end

    assign sq_out = sq_out_q;
    assign nz_out = nz_out_q;

endmodule

// File: tb/tb_papu_pulse_noise.sv
// tb_papu_pulse_noise
//   Directed bench for papu_pulse_noise. A behavioural model predicts both
//   output levels at every rising edge; predictions go through a scoreboard
//   queue and are checked against the DUT one time step after the edge.
//   Follows PAPU_LENGTH_EN the same way the design does.
module tb_papu_pulse_noise;

    logic        clk;
    logic        rst_n;
    logic        apu_ce;
    logic        qframe;
    logic        hframe;
    logic [7:0]  sq_reg0;
    logic [10:0] sq_period;
    logic        sq_restart;
    logic [4:0]  sq_len_idx;
    logic [7:0]  nz_reg0;
    logic [7:0]  nz_reg2;
    logic        nz_restart;
    logic [4:0]  nz_len_idx;
    logic [3:0]  sq_out;
    logic [3:0]  nz_out;

    papu_pulse_noise dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .apu_ce     (apu_ce),
        .qframe     (qframe),
        .hframe     (hframe),
        .sq_reg0    (sq_reg0),
        .sq_period  (sq_period),
        .sq_restart (sq_restart),
        .sq_len_idx (sq_len_idx),
        .nz_reg0    (nz_reg0),
        .nz_reg2    (nz_reg2),
        .nz_restart (nz_restart),
        .nz_len_idx (nz_len_idx),
        .sq_out     (sq_out),
        .nz_out     (nz_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] sq;
        logic [3:0] nz;
    } exp_t;

    exp_t sb_q[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;

    // Reference tables
    logic [7:0]  DUTY [4]  = '{8'b01000000, 8'b01100000, 8'b01111000, 8'b10011111};
    logic [11:0] NT   [16] = '{12'd4, 12'd8, 12'd16, 12'd32, 12'd64, 12'd96, 12'd128, 12'd160,
                               12'd202, 12'd254, 12'd380, 12'd508, 12'd762, 12'd1016, 12'd2034, 12'd4068};
`ifdef PAPU_LENGTH_EN
    logic [7:0]  LT   [32] = '{8'd10, 8'd254, 8'd20, 8'd2, 8'd40, 8'd4, 8'd80, 8'd6,
                               8'd160, 8'd8, 8'd60, 8'd10, 8'd14, 8'd12, 8'd26, 8'd14,
                               8'd12, 8'd16, 8'd24, 8'd18, 8'd48, 8'd20, 8'd96, 8'd22,
                               8'd192, 8'd24, 8'd72, 8'd26, 8'd16, 8'd28, 8'd32, 8'd30};
`endif

    // Model state
    logic [10:0] m_sq_timer;
    logic [2:0]  m_sq_step;
    logic [11:0] m_nz_timer;
    logic [14:0] m_lfsr;
    logic [3:0]  m_decay [2];
    logic [3:0]  m_div   [2];
    logic        m_start [2];
    logic [7:0]  m_len   [2];

    task automatic check(input string tag, input int obs, input int exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Predict outputs for this edge from pre-edge model state, then advance the model.
    task automatic model_edge();
        exp_t       e;
        logic [3:0] vol [2];
        logic       mute [2];
        logic       fb;
        if (!rst_n) begin
            e.sq = 4'd0;
            e.nz = 4'd0;
            sb_q.push_back(e);
            m_sq_timer = '0;
            m_sq_step  = '0;
            m_nz_timer = '0;
            m_lfsr     = 15'h0001;
            for (int ch = 0; ch < 2; ch++) begin
                m_decay[ch] = '0;
                m_div[ch]   = '0;
                m_start[ch] = 1'b0;
                m_len[ch]   = '0;
            end
            return;
        end
        vol[0] = sq_reg0[4] ? sq_reg0[3:0] : m_decay[0];
        vol[1] = nz_reg0[4] ? nz_reg0[3:0] : m_decay[1];
        for (int ch = 0; ch < 2; ch++) begin
`ifdef PAPU_LENGTH_EN
            mute[ch] = (m_len[ch] == 8'd0);
`else
            mute[ch] = 1'b0;
`endif
        end
        e.sq = (DUTY[sq_reg0[7:6]][3'd7 - m_sq_step] && sq_period >= 11'd8 && !mute[0]) ? vol[0] : 4'd0;
        e.nz = (m_lfsr[0] == 1'b0 && !mute[1]) ? vol[1] : 4'd0;
        sb_q.push_back(e);

        if (sq_restart) begin
            m_sq_step  = 3'd0;
            m_sq_timer = sq_period;
        end else if (apu_ce) begin
            if (m_sq_timer == 11'd0) begin
                m_sq_timer = sq_period;
                m_sq_step  = m_sq_step + 3'd1;
            end else begin
                m_sq_timer = m_sq_timer - 11'd1;
            end
        end

        if (apu_ce) begin
            if (m_nz_timer == 12'd0) begin
                m_nz_timer = NT[nz_reg2[3:0]];
                fb         = m_lfsr[0] ^ (nz_reg2[7] ? m_lfsr[6] : m_lfsr[1]);
                m_lfsr     = {fb, m_lfsr[14:1]};
            end else begin
                m_nz_timer = m_nz_timer - 12'd1;
            end
        end

        for (int ch = 0; ch < 2; ch++) begin
            logic [5:0] ctl;
            logic       rs;
            ctl = (ch == 0) ? sq_reg0[5:0] : nz_reg0[5:0];
            rs  = (ch == 0) ? sq_restart : nz_restart;
            if (rs) begin
                m_start[ch] = 1'b1;
            end else if (qframe) begin
                if (m_start[ch]) begin
                    m_start[ch] = 1'b0;
                    m_decay[ch] = 4'd15;
                    m_div[ch]   = ctl[3:0];
                end else if (m_div[ch] == 4'd0) begin
                    m_div[ch] = ctl[3:0];
                    if (m_decay[ch] != 4'd0) m_decay[ch] = m_decay[ch] - 4'd1;
                    else if (ctl[5])         m_decay[ch] = 4'd15;
                end else begin
                    m_div[ch] = m_div[ch] - 4'd1;
                end
            end
`ifdef PAPU_LENGTH_EN
            if (rs) m_len[ch] = LT[(ch == 0) ? sq_len_idx : nz_len_idx];
            else if (hframe && !ctl[5] && m_len[ch] != 8'd0) m_len[ch] = m_len[ch] - 8'd1;
`endif
        end
    endtask

    // One clock: model the edge, then pop the scoreboard and compare 1 time unit later.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        model_edge();
        #1;
        if (sb_q.size() == 0) begin
            check("scoreboard_underflow", 0, 1);
        end else begin
            e = sb_q.pop_front();
            check("sq_out", int'(sq_out), int'(e.sq));
            check("nz_out", int'(nz_out), int'(e.nz));
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Pulse a frame strobe for one cycle, then let a few cycles pass.
    task automatic qpulse(input int gap);
        qframe = 1'b1;
        tick();
        qframe = 1'b0;
        ticks(gap);
    endtask

    task automatic hpulse(input int gap);
        hframe = 1'b1;
        tick();
        hframe = 1'b0;
        ticks(gap);
    endtask

    initial begin
        int hi_cnt;
        int lo_cnt;
        int nz_cnt;
        int exp_seen;

        rst_n      = 1'b0;
        apu_ce     = 1'b0;
        qframe     = 1'b0;
        hframe     = 1'b0;
        sq_reg0    = 8'h00;
        sq_period  = 11'd0;
        sq_restart = 1'b0;
        sq_len_idx = 5'd0;
        nz_reg0    = 8'h1F;
        nz_reg2    = 8'h00;
        nz_restart = 1'b0;
        nz_len_idx = 5'd0;

        // Reset held for three cycles
        ticks(3);
        check("reset_sq_out", int'(sq_out), 0);
        check("reset_nz_out", int'(nz_out), 0);
        $display("step reset: outputs sq=%0d nz=%0d", sq_out, nz_out);

        // Release with pulse 50% duty, C=1 V=2, period 8; noise C=1 V=15, mode 0, P=0
        rst_n      = 1'b1;
        apu_ce     = 1'b1;
        sq_reg0    = 8'h92;
        sq_period  = 11'd8;
        sq_len_idx = 5'd1;
        sq_restart = 1'b1;
        nz_len_idx = 5'd1;
        nz_restart = 1'b1;
        tick();
        check("nz_before_first_shift", int'(nz_out), 0);
        sq_restart = 1'b0;
        nz_restart = 1'b0;
        tick();
        check("nz_after_first_shift", int'(nz_out), 15);
        $display("step release: first LFSR shift seen, nz=%0d", nz_out);

        ticks(10);
        hi_cnt = 0;
        lo_cnt = 0;
        for (int i = 0; i < 72; i++) begin
            tick();
            if (sq_out == 4'd2) hi_cnt++;
            if (sq_out == 4'd0) lo_cnt++;
        end
        check("pulse_high_cycles_72", hi_cnt, 36);
        check("pulse_low_cycles_72", lo_cnt, 36);
        $display("step pulse: high=%0d low=%0d over 72 clocks", hi_cnt, lo_cnt);

        // Period below 8 mutes the pulse
        sq_period = 11'd7;
        nz_cnt    = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (sq_out != 4'd0) nz_cnt++;
        end
        check("pulse_mute_period7", nz_cnt, 0);
        $display("step pulse mute: nonzero samples=%0d", nz_cnt);

        // Noise sequences: mode 0, then mode 1, then a longer period
        sq_period = 11'd8;
        ticks(250);
        nz_reg2 = 8'h80;
        ticks(400);
        nz_reg2 = 8'h83;
        ticks(200);
        $display("step noise: mode 0/1 sequences run");

        // Envelope decay, L=0 then L=1, then divider V=2
        sq_reg0    = 8'h80;
        nz_reg0    = 8'h00;
        nz_reg2    = 8'h00;
        sq_restart = 1'b1;
        nz_restart = 1'b1;
        tick();
        sq_restart = 1'b0;
        nz_restart = 1'b0;
        for (int i = 0; i < 20; i++) qpulse(4);
        sq_reg0 = 8'hA0;
        nz_reg0 = 8'h20;
        for (int i = 0; i < 20; i++) qpulse(4);
        sq_reg0 = 8'h82;
        nz_reg0 = 8'h02;
        for (int i = 0; i < 12; i++) qpulse(3);
        $display("step envelope: decay/loop/divider sequences run");

        // Restart coinciding with qframe: start only, decay moves on the next qframe
        sq_restart = 1'b1;
        nz_restart = 1'b1;
        qframe     = 1'b1;
        tick();
        sq_restart = 1'b0;
        nz_restart = 1'b0;
        qframe     = 1'b0;
        ticks(3);
        qpulse(3);
        qpulse(3);
        $display("step restart+qframe: run");

        // Length counter: idx 3 (=2), L=0, two hframes
        sq_reg0    = 8'h9F;
        sq_len_idx = 5'd3;
        sq_restart = 1'b1;
        hframe     = 1'b1;
        tick();
        sq_restart = 1'b0;
        hframe     = 1'b0;
        ticks(5);
        hpulse(3);
        hpulse(3);
        nz_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (sq_out != 4'd0) nz_cnt++;
        end
`ifdef PAPU_LENGTH_EN
        exp_seen = 0;
`else
        exp_seen = 1;
`endif
        check("length_expired_mute", int'(nz_cnt != 0), exp_seen);
        $display("step length L=0: nonzero samples=%0d", nz_cnt);

        // Length halted with L=1: never muted
        sq_reg0    = 8'hBF;
        sq_restart = 1'b1;
        tick();
        sq_restart = 1'b0;
        hpulse(2);
        hpulse(2);
        hpulse(2);
        nz_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (sq_out != 4'd0) nz_cnt++;
        end
        check("length_halt_not_muted", int'(nz_cnt != 0), 1);
        $display("step length L=1: nonzero samples=%0d", nz_cnt);

        // Mixed traffic with a reset in the middle
        for (int i = 0; i < 600; i++) begin
            apu_ce     = 1'($urandom_range(0, 1));
            qframe     = ($urandom_range(0, 9) == 0);
            hframe     = ($urandom_range(0, 19) == 0);
            sq_restart = ($urandom_range(0, 49) == 0);
            nz_restart = ($urandom_range(0, 49) == 0);
            sq_len_idx = 5'($urandom_range(0, 31));
            nz_len_idx = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 63) == 0) sq_reg0 = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 63) == 0) nz_reg0 = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 63) == 0) nz_reg2 = {1'($urandom_range(0, 1)), 3'd0, 4'($urandom_range(0, 3))};
            if ($urandom_range(0, 63) == 0) sq_period = 11'($urandom_range(5, 20));
            rst_n = (i != 300);
            tick();
        end
        rst_n      = 1'b1;
        qframe     = 1'b0;
        hframe     = 1'b0;
        sq_restart = 1'b0;
        nz_restart = 1'b0;
        $display("step mixed: 600 cycles with mid-run reset");

        check("scoreboard_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
